// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI control-change parameter bank.
package midi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA1 = 2'd1,
        ST_DATA2 = 2'd2,
        ST_SKIP  = 2'd3
    } parse_state_t;

    localparam logic [7:0] STATUS_MASK = 8'hF0;
    localparam logic [7:0] STATUS_CC   = 8'hB0;
    localparam logic [7:0] STATUS_SYS  = 8'hF0;
    localparam logic [7:0] STATUS_RT   = 8'hF8;

    localparam logic [6:0] CC_LSB_BASE = 7'd32;
    localparam logic [6:0] CC_EXT_BASE = 7'd64;

    // Byte-lane enables for one 16-bit entry inside a 32-bit word.
    function automatic logic [3:0] lane_enable(input logic odd, input logic low_only);
        logic [1:0] be;
        be = low_only ? 2'b01 : 2'b11;
        return odd ? {be, 2'b00} : {2'b00, be};
    endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Parameter storage: port A 32-bit byte-enabled read/write, port B 16-bit entry read.
module dual_port_ram #(
    parameter int AW = 6
) (
    input  logic          i_clk,
    input  logic          i_a_re,
    input  logic [3:0]    i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [31:0]   i_a_wdata,
    output logic [31:0]   o_a_q,
    input  logic [AW:0]   i_b_addr,
    output logic [15:0]   o_b_q
);

    logic [31:0] r_mem [2**AW];
    logic [31:0] r_a_q;
    logic [15:0] r_b_q;

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_a_we[i]) r_mem[i_a_addr][8*i +: 8] <= i_a_wdata[8*i +: 8];
        end
        if (i_a_re) r_a_q <= r_mem[i_a_addr];
        // Nonblocking reads return pre-write contents on a same-cycle collision.
        r_b_q <= i_b_addr[0] ? r_mem[i_b_addr[AW:1]][31:16] : r_mem[i_b_addr[AW:1]][15:0];
    end

    assign o_a_q = r_a_q;
    assign o_b_q = r_b_q;

endmodule

// File: rtl/midi_param_bank.sv
// MIDI CC parser feeding a per-channel 16-bit parameter RAM shared with a CPU port.
// Parser: IDLE wait for status | DATA1 expect CC number | DATA2 expect value | SKIP drop data bytes.
module midi_param_bank
    import midi_pkg::*;
#(
    parameter  int CHANNELS   = 4,
    parameter  int NUM_PARAMS = 32,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW         = $clog2(NUM_PARAMS),
    localparam int AW         = CW + PW - 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_midi_valid,
    input  logic [7:0]    i_midi_data,
    output logic          o_midi_ready,
    input  logic          i_cpu_re,
    input  logic [3:0]    i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [31:0]   i_cpu_data,
    output logic [31:0]   o_cpu_q,
    input  logic [AW:0]   i_voice_addr,
    output logic [15:0]   o_voice_q,
    output logic          o_evt_valid,
    output logic [CW-1:0] o_evt_channel,
    output logic [PW-1:0] o_evt_param
);

    parse_state_t  r_state;
    logic          r_run_valid;
    logic [CW-1:0] r_run_ch;
    logic [6:0]    r_cc;
    logic          r_pend_valid;
    logic [CW-1:0] r_pend_ch;
    logic [PW-1:0] r_pend_param;
    logic [15:0]   r_pend_data;
    logic          r_pend_low;
    logic          r_evt_valid;
    logic [CW-1:0] r_evt_channel;
    logic [PW-1:0] r_evt_param;

    logic          w_accept;
    logic          w_cpu_busy;
    logic          w_drain;
    logic          w_ch_ok;
    logic          w_cc_ok;
    logic          w_low_only;
    logic [6:0]    w_tgt;
    logic [3:0]    w_a_we;
    logic [AW-1:0] w_a_addr;
    logic [31:0]   w_a_wdata;

    assign w_accept   = i_midi_valid & ~r_pend_valid;
    assign w_cpu_busy = i_cpu_re | (|i_cpu_we);
    assign w_drain    = r_pend_valid & ~w_cpu_busy;
    assign w_ch_ok    = 32'(i_midi_data[3:0]) < CHANNELS;

    // CC 32..63 are the LSB companions of CC 0..31.
    always_comb begin
        w_tgt      = r_cc;
        w_low_only = 1'b0;
        w_cc_ok    = 1'b0;
        if (r_cc < CC_LSB_BASE) begin
            w_cc_ok = 32'(r_cc) < NUM_PARAMS;
        end else if (r_cc < CC_EXT_BASE) begin
            w_tgt      = r_cc - CC_LSB_BASE;
            w_low_only = 1'b1;
            w_cc_ok    = 32'(w_tgt) < NUM_PARAMS;
        end else begin
            w_cc_ok = 32'(r_cc) < NUM_PARAMS;
        end
    end

    always_comb begin
        w_a_we    = 4'b0000;
        w_a_addr  = i_cpu_addr;
        w_a_wdata = i_cpu_data;
        if (w_cpu_busy) begin
            w_a_we = i_cpu_we;
        end else if (w_drain) begin
            w_a_we    = lane_enable(r_pend_param[0], r_pend_low);
            w_a_addr  = {r_pend_ch, r_pend_param[PW-1:1]};
            w_a_wdata = {r_pend_data, r_pend_data};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_run_valid   <= 1'b0;
            r_run_ch      <= '0;
            r_cc          <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_ch     <= '0;
            r_pend_param  <= '0;
            r_pend_data   <= '0;
            r_pend_low    <= 1'b0;
            r_evt_valid   <= 1'b0;
            r_evt_channel <= '0;
            r_evt_param   <= '0;
        end else begin
            r_evt_valid <= w_drain;
            if (w_drain) begin
                r_pend_valid  <= 1'b0;
                r_evt_channel <= r_pend_ch;
                r_evt_param   <= r_pend_param;
            end
            if (w_accept) begin
                if (i_midi_data >= STATUS_RT) begin
                    r_state <= r_state;
                end else if (i_midi_data >= STATUS_SYS) begin
                    r_run_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end else if (i_midi_data[7]) begin
                    if (((i_midi_data & STATUS_MASK) == STATUS_CC) && w_ch_ok) begin
                        r_run_ch    <= i_midi_data[CW-1:0];
                        r_run_valid <= 1'b1;
                        r_state     <= ST_DATA1;
                    end else begin
                        r_run_valid <= 1'b0;
                        r_state     <= ST_SKIP;
                    end
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (r_run_valid) begin
                                r_cc    <= i_midi_data[6:0];
                                r_state <= ST_DATA2;
                            end
                        end
                        ST_DATA1: begin
                            r_cc    <= i_midi_data[6:0];
                            r_state <= ST_DATA2;
                        end
                        ST_DATA2: begin
                            r_state <= ST_DATA1;
                            if (w_cc_ok) begin
                                r_pend_valid <= 1'b1;
                                r_pend_ch    <= r_run_ch;
                                r_pend_param <= w_tgt[PW-1:0];
                                r_pend_low   <= w_low_only;
                                r_pend_data  <= w_low_only ? {9'd0, i_midi_data[6:0]}
                                                           : {1'b0, i_midi_data[6:0], 8'h00};
                            end
                        end
                        ST_SKIP: r_state <= ST_SKIP;
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    dual_port_ram #(.AW(AW)) u_ram (
        .i_clk     (i_clk),
        .i_a_re    (i_cpu_re),
        .i_a_we    (w_a_we),
        .i_a_addr  (w_a_addr),
        .i_a_wdata (w_a_wdata),
        .o_a_q     (o_cpu_q),
        .i_b_addr  (i_voice_addr),
        .o_b_q     (o_voice_q)
    );

    assign o_midi_ready  = ~r_pend_valid;
    assign o_evt_valid   = r_evt_valid;
    assign o_evt_channel = r_evt_channel;
    assign o_evt_param   = r_evt_param;

endmodule

// File: tb/tb_midi_param_bank.sv
// Directed bench for midi_param_bank with default parameters (4 channels, 32 params).
module tb_midi_param_bank;

    localparam int CW = 2;
    localparam int PW = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_midi_valid = 1'b0;
    logic [7:0]  i_midi_data = 8'h00;
    logic        o_midi_ready;
    logic        i_cpu_re = 1'b0;
    logic [3:0]  i_cpu_we = 4'h0;
    logic [5:0]  i_cpu_addr = '0;
    logic [31:0] i_cpu_data = '0;
    logic [31:0] o_cpu_q;
    logic [6:0]  i_voice_addr = '0;
    logic [15:0] o_voice_q;
    logic        o_evt_valid;
    logic [CW-1:0] o_evt_channel;
    logic [PW-1:0] o_evt_param;

    int checks = 0;
    int fails  = 0;
    int evt_cnt = 0;
    logic [CW-1:0] last_ch = '0;
    logic [PW-1:0] last_param = '0;

    midi_param_bank dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_midi_valid  (i_midi_valid),
        .i_midi_data   (i_midi_data),
        .o_midi_ready  (o_midi_ready),
        .i_cpu_re      (i_cpu_re),
        .i_cpu_we      (i_cpu_we),
        .i_cpu_addr    (i_cpu_addr),
        .i_cpu_data    (i_cpu_data),
        .o_cpu_q       (o_cpu_q),
        .i_voice_addr  (i_voice_addr),
        .o_voice_q     (o_voice_q),
        .o_evt_valid   (o_evt_valid),
        .o_evt_channel (o_evt_channel),
        .o_evt_param   (o_evt_param)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && o_evt_valid) begin
            evt_cnt    <= evt_cnt + 1;
            last_ch    <= o_evt_channel;
            last_param <= o_evt_param;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!o_midi_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_midi_ready) begin
            checks++;
            fails++;
            $display("FAIL send_ready: midi_ready stuck low for byte %02h", b);
        end else begin
            i_midi_valid = 1'b1;
            i_midi_data  = b;
            @(negedge clk);
            i_midi_valid = 1'b0;
        end
    endtask

    task automatic read_voice(input logic [6:0] a, output logic [15:0] d);
        i_voice_addr = a;
        @(negedge clk);
        d = o_voice_q;
    endtask

    task automatic cpu_read(input logic [5:0] a, output logic [31:0] d);
        i_cpu_re   = 1'b1;
        i_cpu_addr = a;
        @(negedge clk);
        i_cpu_re = 1'b0;
        d = o_cpu_q;
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] we);
        i_cpu_we   = we;
        i_cpu_addr = a;
        i_cpu_data = d;
        @(negedge clk);
        i_cpu_we = 4'h0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        checks++;
        if (o_midi_ready !== 1'b1 || o_evt_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: ready=%b evt=%b, want ready=1 evt=0", o_midi_ready, o_evt_valid);
        end
        checks++;
        if (o_evt_channel !== '0 || o_evt_param !== '0) begin
            fails++;
            $display("FAIL reset_evt: ch=%0d param=%0d, want 0/0", o_evt_channel, o_evt_param);
        end
        rst = 1'b0;
        idle(1);
        for (int w = 0; w < 64; w++) cpu_write(6'(w), 32'h0, 4'hF);
    endtask

    task automatic test_cc_msb;
        int e0;
        logic [15:0] v;
        logic [31:0] q;
        e0 = evt_cnt;
        send_byte(8'hB0); send_byte(8'h07); send_byte(8'h64);
        idle(3);
        checks++;
        if (evt_cnt != e0 + 1 || last_ch !== 2'd0 || last_param !== 5'd7) begin
            fails++;
            $display("FAIL msb_evt: cnt=%0d ch=%0d param=%0d, want cnt=%0d ch=0 param=7", evt_cnt, last_ch, last_param, e0 + 1);
        end
        read_voice(7'd7, v);
        checks++;
        if (v !== 16'h6400) begin
            fails++;
            $display("FAIL msb_voice: got %04h want 6400", v);
        end
        cpu_read(6'd3, q);
        checks++;
        if (q !== 32'h6400_0000) begin
            fails++;
            $display("FAIL msb_cpu: got %08h want 64000000", q);
        end
    endtask

    task automatic test_running_status;
        int e0;
        logic [15:0] v;
        e0 = evt_cnt;
        send_byte(8'hB1); send_byte(8'h03); send_byte(8'h40);
        send_byte(8'h23); send_byte(8'h11);
        idle(3);
        checks++;
        if (evt_cnt != e0 + 2 || last_ch !== 2'd1 || last_param !== 5'd3) begin
            fails++;
            $display("FAIL running_evt: cnt=%0d ch=%0d param=%0d, want cnt=%0d ch=1 param=3", evt_cnt, last_ch, last_param, e0 + 2);
        end
        read_voice(7'd35, v);
        checks++;
        if (v !== 16'h4011) begin
            fails++;
            $display("FAIL running_voice: got %04h want 4011", v);
        end
    endtask

    task automatic test_cpu_priority;
        logic [15:0] v;
        logic [31:0] q;
        send_byte(8'hB0); send_byte(8'h05);
        i_midi_valid = 1'b1;
        i_midi_data  = 8'h2A;
        @(negedge clk);
        i_midi_valid = 1'b0;
        i_cpu_we   = 4'hF;
        i_cpu_addr = 6'd20;
        i_cpu_data = 32'hCAFE_F00D;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (o_midi_ready !== 1'b0 || o_evt_valid !== 1'b0) begin
                fails++;
                $display("FAIL prio_hold%0d: ready=%b evt=%b, want 0/0", c, o_midi_ready, o_evt_valid);
            end
            @(negedge clk);
        end
        i_cpu_we = 4'h0;
        checks++;
        if (o_midi_ready !== 1'b0 || o_evt_valid !== 1'b0) begin
            fails++;
            $display("FAIL prio_drain: ready=%b evt=%b, want 0/0", o_midi_ready, o_evt_valid);
        end
        @(negedge clk);
        checks++;
        if (o_evt_valid !== 1'b1 || o_evt_param !== 5'd5 || o_midi_ready !== 1'b1) begin
            fails++;
            $display("FAIL prio_evt: evt=%b param=%0d ready=%b, want 1/5/1", o_evt_valid, o_evt_param, o_midi_ready);
        end
        read_voice(7'd5, v);
        checks++;
        if (v !== 16'h2A00) begin
            fails++;
            $display("FAIL prio_voice: got %04h want 2a00", v);
        end
        cpu_read(6'd20, q);
        checks++;
        if (q !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL prio_cpu: got %08h want cafef00d", q);
        end
    endtask

    task automatic test_same_entry;
        logic [31:0] q;
        send_byte(8'hB0); send_byte(8'h06);
        i_midi_valid = 1'b1;
        i_midi_data  = 8'h33;
        @(negedge clk);
        i_midi_valid = 1'b0;
        i_cpu_we   = 4'hF;
        i_cpu_addr = 6'd3;
        i_cpu_data = 32'h1234_5678;
        @(negedge clk);
        i_cpu_we = 4'h0;
        idle(3);
        cpu_read(6'd3, q);
        checks++;
        if (q !== 32'h1234_3300) begin
            fails++;
            $display("FAIL same_entry: got %08h want 12343300", q);
        end
    endtask

    task automatic test_channel_filter;
        int e0;
        logic [15:0] v;
        e0 = evt_cnt;
        send_byte(8'hB5); send_byte(8'h07); send_byte(8'h7F);
        idle(3);
        checks++;
        if (evt_cnt != e0) begin
            fails++;
            $display("FAIL chan_filter: events=%0d want %0d", evt_cnt, e0);
        end
        send_byte(8'hB0); send_byte(8'h07); send_byte(8'h01);
        idle(3);
        read_voice(7'd7, v);
        checks++;
        if (v !== 16'h0100 || evt_cnt != e0 + 1) begin
            fails++;
            $display("FAIL chan_after: entry=%04h events=%0d, want 0100/%0d", v, evt_cnt, e0 + 1);
        end
    endtask

    task automatic test_realtime_and_abandon;
        int e0;
        logic [15:0] v;
        send_byte(8'hB0); send_byte(8'h07); send_byte(8'hF8); send_byte(8'h50);
        idle(3);
        read_voice(7'd7, v);
        checks++;
        if (v !== 16'h5000) begin
            fails++;
            $display("FAIL realtime: got %04h want 5000", v);
        end
        e0 = evt_cnt;
        send_byte(8'hB0); send_byte(8'h07); send_byte(8'h90);
        send_byte(8'h22); send_byte(8'h33);
        idle(3);
        read_voice(7'd7, v);
        checks++;
        if (evt_cnt != e0 || v !== 16'h5000) begin
            fails++;
            $display("FAIL abandon: events=%0d entry=%04h, want %0d/5000", evt_cnt, v, e0);
        end
    endtask

    task automatic test_lsb_and_range;
        int e0;
        logic [15:0] v;
        e0 = evt_cnt;
        send_byte(8'hB0); send_byte(8'h40); send_byte(8'h11);
        idle(3);
        checks++;
        if (evt_cnt != e0) begin
            fails++;
            $display("FAIL cc_range: events=%0d want %0d", evt_cnt, e0);
        end
        send_byte(8'hB0); send_byte(8'h27); send_byte(8'h05);
        idle(3);
        read_voice(7'd7, v);
        checks++;
        if (v !== 16'h5005 || evt_cnt != e0 + 1) begin
            fails++;
            $display("FAIL cc_lsb: entry=%04h events=%0d, want 5005/%0d", v, evt_cnt, e0 + 1);
        end
        send_byte(8'hB3); send_byte(8'h1F); send_byte(8'h7F);
        idle(3);
        read_voice(7'd127, v);
        checks++;
        if (v !== 16'h7F00 || last_ch !== 2'd3 || last_param !== 5'd31) begin
            fails++;
            $display("FAIL cc_edge: entry=%04h ch=%0d param=%0d, want 7f00/3/31", v, last_ch, last_param);
        end
    endtask

    task automatic test_sysex;
        int e0;
        logic [15:0] v;
        e0 = evt_cnt;
        send_byte(8'hB0); send_byte(8'hF0); send_byte(8'h07); send_byte(8'h64);
        idle(3);
        read_voice(7'd7, v);
        checks++;
        if (evt_cnt != e0 || v !== 16'h5005) begin
            fails++;
            $display("FAIL sysex: events=%0d entry=%04h, want %0d/5005", evt_cnt, v, e0);
        end
    endtask

    task automatic test_reset_mid;
        int e0;
        logic [15:0] v;
        send_byte(8'hB0); send_byte(8'h07);
        rst = 1'b1;
        idle(1);
        checks++;
        if (o_evt_channel !== '0 || o_evt_param !== '0 || o_midi_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_out: ch=%0d param=%0d ready=%b, want 0/0/1", o_evt_channel, o_evt_param, o_midi_ready);
        end
        rst = 1'b0;
        idle(1);
        e0 = evt_cnt;
        send_byte(8'h07); send_byte(8'h64);
        idle(3);
        read_voice(7'd7, v);
        checks++;
        if (evt_cnt != e0 || v !== 16'h5005) begin
            fails++;
            $display("FAIL rst_mid: events=%0d entry=%04h, want %0d/5005", evt_cnt, v, e0);
        end
    endtask

    task automatic test_cpu_q_hold;
        logic [31:0] q;
        cpu_read(6'd3, q);
        checks++;
        if (q !== 32'h5005_3300) begin
            fails++;
            $display("FAIL cpu_read: got %08h want 50053300", q);
        end
        i_cpu_addr = 6'd20;
        idle(3);
        checks++;
        if (o_cpu_q !== 32'h5005_3300) begin
            fails++;
            $display("FAIL cpu_hold: got %08h want 50053300", o_cpu_q);
        end
    endtask

    task automatic test_voice_rbw;
        logic [31:0] q;
        i_voice_addr = 7'd40;
        i_cpu_we     = 4'b0001;
        i_cpu_addr   = 6'd20;
        i_cpu_data   = 32'h0000_00AA;
        @(negedge clk);
        i_cpu_we = 4'h0;
        checks++;
        if (o_voice_q !== 16'hF00D) begin
            fails++;
            $display("FAIL voice_rbw_old: got %04h want f00d", o_voice_q);
        end
        @(negedge clk);
        checks++;
        if (o_voice_q !== 16'hF0AA) begin
            fails++;
            $display("FAIL voice_rbw_new: got %04h want f0aa", o_voice_q);
        end
        cpu_read(6'd20, q);
        checks++;
        if (q !== 32'hCAFE_F0AA) begin
            fails++;
            $display("FAIL byte_lane: got %08h want cafef0aa", q);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_cc_msb;
        test_running_status;
        test_cpu_priority;
        test_same_entry;
        test_channel_filter;
        test_realtime_and_abandon;
        test_lsb_and_range;
        test_sysex;
        test_reset_mid;
        test_cpu_q_hold;
        test_voice_rbw;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
